// File: rtl/ps2_interface.sv
// Receive-only PS/2 keyboard port: synchronized, deglitched line inputs
// feeding an 11-bit frame assembler with timeout and a one-cycle report strobe.

module ps2_line_filter #(
  parameter int LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic filt_o
);

  localparam int FW = (LEN > 1) ? $clog2(LEN + 1) : 1;
  localparam logic [FW-1:0] CNT_LAST = FW'(LEN - 1);
  localparam logic [FW-1:0] CNT_ONE  = FW'(1);

  logic [1:0]    sync_q;
  logic [FW-1:0] cnt_q;
  logic [FW-1:0] cnt_d;
  logic          filt_q;
  logic          filt_d;

  // Two-flop synchronizer; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

  // Flip the filtered level only after LEN consecutive differing samples.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Filter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

module ps2_interface #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  output logic [7:0] rx_data,
  output logic       read_data,
  output logic       busy,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DONE
  } state_t;

  // Host never drives the bus; lines are sensed only.
  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

  logic clk_f;
  logic data_f;
  logic clk_prev_q;
  logic fall;

  ps2_line_filter #(.LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_clk),
    .filt_o (clk_f)
  );

  ps2_line_filter #(.LEN(FILTER_LEN)) u_data_filt (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_data),
    .filt_o (data_f)
  );

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_f;
    end
  end

  assign fall = clk_prev_q & ~clk_f;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    bit_q;
  logic [3:0]    bit_d;
  logic [9:0]    shift_q;
  logic [9:0]    shift_d;
  logic [9:0]    shift_nxt;
  logic [TW-1:0] to_q;
  logic [TW-1:0] to_d;
  logic [7:0]    rx_q;
  logic [7:0]    rx_d;
  logic          rd_q;
  logic          rd_d;
  logic          err_q;
  logic          err_d;
  logic          busy_q;
  logic          busy_d;
  logic          frame_ok;

  // Incoming bit enters at the top so data bit 0 ends up at index 0.
  // Start bit is already known to be 0 from the IDLE entry condition.
  assign shift_nxt = {data_f, shift_q[9:1]};
  assign frame_ok  = (^shift_nxt[8:0]) & shift_nxt[9];

  // Frame FSM: next state, counters and registered report outputs.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    to_d    = to_q;
    rx_d    = rx_q;
    rd_d    = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        to_d = '0;
        if (fall && !data_f) begin
          state_d = S_RECV;
          busy_d  = 1'b1;
          bit_d   = 4'd0;
          shift_d = '0;
        end
      end
      S_RECV: begin
        if (fall) begin
          shift_d = shift_nxt;
          to_d    = '0;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            rd_d    = 1'b1;
            if (frame_ok) begin
              rx_d = shift_nxt[7:0];
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          rd_d    = 1'b1;
          err_d   = 1'b1;
          to_d    = '0;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      to_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      to_q    <= to_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data   = rx_q;
  assign read_data = rd_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_interface.sv
// Scoreboard bench for ps2_interface: directed frames, glitches,
// timeout and mid-frame reset.

module tb_ps2_interface;

  localparam int HALF = 100;
  localparam int TO   = 500;
  localparam int LAT  = 11;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         t_lo;
    int         t_hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_line = 1'b1;
  logic       data_line = 1'b1;
  wire        ps2_clk_w;
  wire        ps2_data_w;
  logic [7:0] rx_data;
  logic       read_data;
  logic       busy;
  logic       err;

  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   t_last = 0;
  exp_t q[$];

  assign ps2_clk_w  = clk_line;
  assign ps2_data_w = data_line;

  ps2_interface #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk_w),
    .ps2_data  (ps2_data_w),
    .rx_data   (rx_data),
    .read_data (read_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e,
                      input int lo, input int hi);
    exp_t x;
    x.d = d;
    x.e = e;
    x.t_lo = lo;
    x.t_hi = hi;
    q.push_back(x);
  endtask

  // Drive the first nbits of a frame; pflip corrupts parity.
  task automatic send_bits(input logic [7:0] d, input logic pflip,
                           input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      data_line = fr[i];
      if (i == 1) chk("busy_in_frame", int'(busy), 1);
      wait_cyc(HALF);
      clk_line = 1'b0;
      t_last = cyc;
      wait_cyc(HALF);
      clk_line = 1'b1;
    end
    data_line = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      wait_cyc(1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: every strobe must match the oldest expected report.
  always @(negedge clk) begin
    if (read_data) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_strobe: rx=%0h err=%0b expected none",
                 rx_data, err);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("strobe_err", int'(err), int'(x.e));
        chk("strobe_rx", int'(rx_data), int'(x.d));
        chk("strobe_busy", int'(busy), 0);
        if (x.t_lo >= 0) begin
          checks++;
          if (cyc < x.t_lo || cyc > x.t_hi) begin
            fails++;
            $display("FAIL strobe_time: got %0d expected %0d..%0d",
                     cyc, x.t_lo, x.t_hi);
          end
        end
      end
    end
  end

  initial begin
    wait_cyc(3);
    chk("rst_rx", int'(rx_data), 0);
    chk("rst_rd", int'(read_data), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    wait_cyc(20);

    // Good frame, then back-to-back frames.
    push(8'h1C, 1'b0, -1, -1);
    send_bits(8'h1C, 1'b0, 11);
    push(8'hF0, 1'b0, -1, -1);
    send_bits(8'hF0, 1'b0, 11);
    push(8'h1C, 1'b0, -1, -1);
    send_bits(8'h1C, 1'b0, 11);
    drain();

    // Parity error keeps the previous good byte.
    push(8'hF0, 1'b0, -1, -1);
    send_bits(8'hF0, 1'b0, 11);
    push(8'hF0, 1'b1, -1, -1);
    send_bits(8'h1C, 1'b1, 11);
    drain();

    // Short glitches while idle.
    wait_cyc(20);
    clk_line = 1'b0;
    wait_cyc(3);
    clk_line = 1'b1;
    wait_cyc(20);
    data_line = 1'b0;
    wait_cyc(3);
    data_line = 1'b1;
    wait_cyc(20);
    chk("glitch_busy", int'(busy), 0);
    clk_line = 1'b0;
    wait_cyc(3);
    clk_line = 1'b1;
    wait_cyc(30);
    chk("glitch_busy2", int'(busy), 0);

    // Timeout after 5 bits, then a normal frame.
    send_bits(8'h1C, 1'b0, 5);
    push(8'hF0, 1'b1, t_last + LAT + TO - 2, t_last + LAT + TO + 2);
    drain();
    wait_cyc(20);
    push(8'h1C, 1'b0, -1, -1);
    send_bits(8'h1C, 1'b0, 11);
    drain();

    // Mid-frame reset drops the partial frame.
    push(8'hF0, 1'b0, -1, -1);
    send_bits(8'hF0, 1'b0, 11);
    drain();
    send_bits(8'h1C, 1'b0, 4);
    chk("pre_rst_busy", int'(busy), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_rx", int'(rx_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rd", int'(read_data), 0);
    chk("mid_rst_err", int'(err), 0);
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(HALF * 3);
    chk("post_rst_busy", int'(busy), 0);
    push(8'h1C, 1'b0, -1, -1);
    send_bits(8'h1C, 1'b0, 11);
    drain();
    wait_cyc(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
